// File: rtl/hsem_pkg.sv
// Shared constants, AHB encodings and FSM state type for the HSEM bus interface.
package hsem_pkg;

    localparam int HSEM_DATA_WIDTH = 32;
    localparam int HSEM_ADDR_WIDTH = 8;

    // Register offsets of the semaphore block
    localparam logic [7:0] HSEM_OFS_00 = 8'h00;
    localparam logic [7:0] HSEM_OFS_04 = 8'h04;
    localparam logic [7:0] HSEM_OFS_08 = 8'h08;
    localparam logic [7:0] HSEM_OFS_0C = 8'h0C;
    localparam logic [7:0] HSEM_OFS_10 = 8'h10;
    localparam logic [7:0] HSEM_OFS_14 = 8'h14;
    localparam logic [7:0] HSEM_OFS_18 = 8'h18;
    localparam logic [7:0] HSEM_OFS_1C = 8'h1C;
    localparam logic [7:0] HSEM_OFS_20 = 8'h20;
    localparam logic [7:0] HSEM_OFS_24 = 8'h24;
    localparam logic [7:0] HSEM_OFS_28 = 8'h28;
    localparam logic [7:0] HSEM_OFS_2C = 8'h2C;
    localparam logic [7:0] HSEM_OFS_30 = 8'h30;
    localparam logic [7:0] HSEM_OFS_34 = 8'h34;

    localparam logic [7:0] HSEM_MAX_OFFSET = HSEM_OFS_34;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } hsem_state_e;

    // True for the transfer types that carry a real access
    function automatic logic htrans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/hsem_addr_chk.sv
// Address-phase legality check: word size, word alignment and offset range.
module hsem_addr_chk
    import hsem_pkg::*;
#(
    parameter int                            AHB_SEM_ADDR_WIDTH = HSEM_ADDR_WIDTH,
    parameter logic [AHB_SEM_ADDR_WIDTH-1:0] MAX_OFFSET         = HSEM_MAX_OFFSET
) (
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    output logic        illegal
);

    // Any one violation makes the transfer illegal
    always_comb begin
        illegal = (hsize != HSIZE_WORD)
               || (haddr[1:0] != 2'b00)
               || (haddr[AHB_SEM_ADDR_WIDTH-1:0] > MAX_OFFSET)
               || (haddr[31:AHB_SEM_ADDR_WIDTH] != '0);
    end

endmodule

// File: rtl/hsem_biu.sv
// AHB-Lite slave bus interface for the HSEM register file: zero-wait legal
// accesses, two-cycle ERROR response for illegal ones.
module hsem_biu
    import hsem_pkg::*;
#(
    parameter int                            AHB_DATA_WIDTH     = HSEM_DATA_WIDTH,
    parameter int                            AHB_SEM_ADDR_WIDTH = HSEM_ADDR_WIDTH,
    parameter logic [AHB_SEM_ADDR_WIDTH-1:0] MAX_OFFSET         = HSEM_MAX_OFFSET
) (
    input  logic                          hclk,
    input  logic                          hresetn,
    // AHB-Lite request
    input  logic                          hsel,
    input  logic [31:0]                   haddr,
    input  logic [1:0]                    htrans,
    input  logic                          hwrite,
    input  logic [2:0]                    hsize,
    input  logic [AHB_DATA_WIDTH-1:0]     hwdata,
    input  logic                          hready,
    input  logic [3:0]                    hmaster,
    // AHB-Lite response
    output logic                          hreadyout,
    output logic                          hresp,
    output logic [AHB_DATA_WIDTH-1:0]     hrdata,
    // Register file side
    output logic                          wr_en,
    output logic                          rd_en,
    output logic [AHB_SEM_ADDR_WIDTH-1:0] reg_addr,
    output logic [AHB_DATA_WIDTH-1:0]     ihwdata,
    output logic [3:0]                    master_id,
    input  logic [AHB_DATA_WIDTH-1:0]     ihrdata
);

    hsem_state_e                   state_q, state_d;
    logic                          hreadyout_q;
    logic                          hresp_q;
    logic [AHB_SEM_ADDR_WIDTH-1:0] addr_q;
    logic                          write_q;
    logic [3:0]                    master_q;
    logic                          illegal;
    logic                          accept;

    hsem_addr_chk #(
        .AHB_SEM_ADDR_WIDTH (AHB_SEM_ADDR_WIDTH),
        .MAX_OFFSET         (MAX_OFFSET)
    ) u_addr_chk (
        .haddr   (haddr),
        .hsize   (hsize),
        .illegal (illegal)
    );

    // Address phase is taken only when selected, ready and a real transfer; never in ERR1
    always_comb begin
        accept = hsel && hready && htrans_active(htrans) && (state_q != ST_ERR1);
    end

    // Next state: ERR1 always completes into ERR2, every other state follows the accept rules
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            state_d = illegal ? ST_ERR1 : ST_DATA;
        end
    end

    // State, registered response outputs and captured address-phase controls
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            master_q    <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= (state_d != ST_ERR1);
            hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            if (accept) begin
                addr_q   <= haddr[AHB_SEM_ADDR_WIDTH-1:0];
                write_q  <= hwrite;
                master_q <= hmaster;
            end
        end
    end

    // Data-phase strobes and data muxing; DATA is only ever entered for legal transfers
    always_comb begin
        wr_en     = (state_q == ST_DATA) && write_q;
        rd_en     = (state_q == ST_DATA) && !write_q;
        ihwdata   = wr_en ? hwdata : '0;
        hrdata    = rd_en ? ihrdata : '0;
        hreadyout = hreadyout_q;
        hresp     = hresp_q;
        reg_addr  = addr_q;
        master_id = master_q;
    end

endmodule

// File: tb/tb_hsem_biu.sv
// Directed scoreboard bench for hsem_biu with a small register-file model.
module tb_hsem_biu;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [3:0]  hmaster;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  reg_addr;
    logic [31:0] ihwdata;
    logic [3:0]  master_id;
    logic [31:0] ihrdata;

    hsem_biu #(
        .AHB_DATA_WIDTH     (32),
        .AHB_SEM_ADDR_WIDTH (8),
        .MAX_OFFSET         (8'h34)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hmaster   (hmaster),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .reg_addr  (reg_addr),
        .ihwdata   (ihwdata),
        .master_id (master_id),
        .ihrdata   (ihrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Register file environment: written by the DUT strobes, read combinationally
    logic [31:0] env_mem [16] = '{default: '0};
    logic        preload;
    always @(posedge hclk) begin
        if (preload) env_mem[12] <= 32'h0000_00A5;
        else if (wr_en) env_mem[reg_addr[5:2]] <= ihwdata;
    end
    assign ihrdata = env_mem[reg_addr[5:2]];

    typedef struct {
        logic        wr_en;
        logic        rd_en;
        logic [7:0]  reg_addr;
        logic [31:0] ihwdata;
        logic [3:0]  master_id;
        logic        hreadyout;
        logic        hresp;
        logic [31:0] hrdata;
    } exp_t;

    exp_t        sb[$];
    string       tagq[$];
    logic [31:0] shadow [16];
    logic [7:0]  last_addr;
    logic [3:0]  last_mst;
    logic        pend_v;
    logic [31:0] pend_wd;
    logic        in_err1;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic w, input logic r, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] m, input logic rdy,
                        input logic rsp, input logic [31:0] rd);
        exp_t e;
        e.wr_en = w; e.rd_en = r; e.reg_addr = a; e.ihwdata = wd; e.master_id = m;
        e.hreadyout = rdy; e.hresp = rsp; e.hrdata = rd;
        sb.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic check_front();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            t = tagq.pop_front();
            check({t, ".wr_en"},     {31'd0, wr_en},     {31'd0, e.wr_en});
            check({t, ".rd_en"},     {31'd0, rd_en},     {31'd0, e.rd_en});
            check({t, ".reg_addr"},  {24'd0, reg_addr},  {24'd0, e.reg_addr});
            check({t, ".ihwdata"},   ihwdata,            e.ihwdata);
            check({t, ".master_id"}, {28'd0, master_id}, {28'd0, e.master_id});
            check({t, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, e.hreadyout});
            check({t, ".hresp"},     {31'd0, hresp},     {31'd0, e.hresp});
            check({t, ".hrdata"},    hrdata,             e.hrdata);
        end
    endtask

    // One bus cycle: drive the address phase (and the data of the previous write),
    // check this cycle's data phase, then queue what the next cycle must show.
    task automatic step(input string tag, input logic sel, input logic rdy, input logic [1:0] tr,
                        input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] mst);
        logic acc;
        logic legal;
        hwdata  = pend_v ? pend_wd : $urandom();
        hsel    = sel;
        hready  = rdy;
        htrans  = tr;
        hwrite  = wr;
        haddr   = addr;
        hsize   = sz;
        hmaster = mst;
        @(negedge hclk);
        check_front();
        acc    = sel && rdy && (tr == 2'b10 || tr == 2'b11);
        pend_v = 1'b0;
        if (in_err1) begin
            in_err1 = 1'b0;
        end else if (acc) begin
            last_addr = addr[7:0];
            last_mst  = mst;
            legal = (sz == 3'd2) && (addr[1:0] == 2'b00) && (addr <= 32'h34);
            if (!legal) begin
                push({tag, "/err1"}, 1'b0, 1'b0, addr[7:0], 32'd0, mst, 1'b0, 1'b1, 32'd0);
                push({tag, "/err2"}, 1'b0, 1'b0, addr[7:0], 32'd0, mst, 1'b1, 1'b1, 32'd0);
                in_err1 = 1'b1;
            end else if (wr) begin
                push(tag, 1'b1, 1'b0, addr[7:0], wd, mst, 1'b1, 1'b0, 32'd0);
                shadow[addr[5:2]] = wd;
                pend_v  = 1'b1;
                pend_wd = wd;
            end else begin
                push(tag, 1'b0, 1'b1, addr[7:0], 32'd0, mst, 1'b1, 1'b0, shadow[addr[5:2]]);
            end
        end else begin
            push({tag, "/idle"}, 1'b0, 1'b0, last_addr, 32'd0, last_mst, 1'b1, 1'b0, 32'd0);
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 3'd2, 32'd0, 4'd0);
    endtask

    // Assert reset mid-cycle; any pending data phase is expected to be aborted
    task automatic reset_phase(input int unsigned cycles);
        hwdata  = pend_v ? pend_wd : 32'd0;
        hresetn = 1'b0;
        hsel = 1'b0; hready = 1'b1; htrans = 2'b00; hwrite = 1'b0;
        haddr = '0; hsize = 3'd2; hmaster = '0;
        pend_v = 1'b0; in_err1 = 1'b0; last_addr = '0; last_mst = '0;
        #1;
        sb.delete();
        tagq.delete();
        for (int unsigned i = 0; i < cycles; i++) begin
            push("reset", 1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
            @(negedge hclk);
            check_front();
            @(posedge hclk);
            #1;
        end
        hresetn = 1'b1;
        push("post_reset", 1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        preload  = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        shadow[12] = 32'h0000_00A5;
        hresetn = 1'b0;
        pend_v = 1'b0; pend_wd = '0; in_err1 = 1'b0;
        reset_phase(2);
        preload = 1'b0;

        // single write and single read
        step("wr04", 1'b1, 1'b1, 2'b10, 1'b1, 32'h04, 3'd2, 32'h0000_0101, 4'd1);
        idle("after_wr04");
        step("rd30", 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 3'd2, 32'd0, 4'd2);
        idle("after_rd30");

        // illegal offset; the ERR1 cycle presents a transfer that must be ignored
        step("wr38", 1'b1, 1'b1, 2'b10, 1'b1, 32'h38, 3'd2, 32'h1234_5678, 4'd3);
        step("err1_drv", 1'b1, 1'b0, 2'b10, 1'b1, 32'h08, 3'd2, 32'hFFFF_FFFF, 4'd3);
        idle("after_wr38");
        idle("quiet0");

        // illegal size
        step("rd00_byte", 1'b1, 1'b1, 2'b10, 1'b0, 32'h00, 3'd0, 32'd0, 4'd4);
        idle("err1_rd00");
        idle("after_rd00");

        // misaligned, and out of the 8-bit window; a legal read accepted during ERR2
        step("rd02_unal", 1'b1, 1'b1, 2'b10, 1'b0, 32'h02, 3'd2, 32'd0, 4'd5);
        idle("err1_unal");
        idle("after_unal");
        step("rd100_hi", 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 3'd2, 32'd0, 4'd6);
        idle("err1_hi");
        step("rd30_in_err2", 1'b1, 1'b1, 2'b11, 1'b0, 32'h30, 3'd2, 32'd0, 4'd7);
        idle("after_err2_acc");

        // non-transfers: BUSY, IDLE with hsel, hready low
        step("busy", 1'b1, 1'b1, 2'b01, 1'b1, 32'h04, 3'd2, 32'd0, 4'd8);
        step("htr_idle", 1'b1, 1'b1, 2'b00, 1'b1, 32'h04, 3'd2, 32'd0, 4'd8);
        step("nready", 1'b1, 1'b0, 2'b10, 1'b1, 32'h04, 3'd2, 32'd0, 4'd8);
        idle("quiet1");

        // back-to-back write / read / write
        step("b2b_wr08", 1'b1, 1'b1, 2'b10, 1'b1, 32'h08, 3'd2, 32'h0000_0001, 4'd1);
        step("b2b_rd08", 1'b1, 1'b1, 2'b11, 1'b0, 32'h08, 3'd2, 32'd0, 4'd2);
        step("b2b_wr0c", 1'b1, 1'b1, 2'b11, 1'b1, 32'h0C, 3'd2, 32'h0000_0201, 4'd3);
        idle("after_b2b");
        step("rd0c", 1'b1, 1'b1, 2'b10, 1'b0, 32'h0C, 3'd2, 32'd0, 4'd3);

        // highest legal offset
        step("wr34", 1'b1, 1'b1, 2'b10, 1'b1, 32'h34, 3'd2, 32'hCAFE_0034, 4'd15);
        step("rd34", 1'b1, 1'b1, 2'b10, 1'b0, 32'h34, 3'd2, 32'd0, 4'd14);
        idle("after_34");

        // reset during a write data phase, then a normal read
        step("wr10_aborted", 1'b1, 1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 4'd9);
        reset_phase(2);
        step("rd30_post_rst", 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 3'd2, 32'd0, 4'd10);
        idle("after_rst_rd");
        idle("final");
        // the aborted write must not have reached the register file
        check("env_mem10_untouched", env_mem[4], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
